// File: rtl/npc_defs.sv
// npc_defs: NPCop encodings, sequencer FSM states and the default reset PC.
package npc_defs;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [3:0] JUMP = 4'b0000;
    localparam logic [3:0] JAL  = 4'b0001;
    localparam logic [3:0] BEQ  = 4'b0010;
    localparam logic [3:0] BNE  = 4'b0011;
    localparam logic [3:0] BGEZ = 4'b0100;
    localparam logic [3:0] BGTZ = 4'b0101;
    localparam logic [3:0] BLEZ = 4'b0110;
    localparam logic [3:0] BLTZ = 4'b0111;
    localparam logic [3:0] JR   = 4'b1000;
    localparam logic [3:0] JALR = 4'b1000;
    localparam logic [3:0] ADD4 = 4'b1111;
    typedef enum logic [1:0] {RUN, WAIT, WAIT_KILL} state_t;
endpackage

// File: rtl/pc_sequencer_branch_cond.sv
// branch_cond: decides whether the EX-stage conditional branch is taken.
module branch_cond
    import npc_defs::*;
(
    input  logic [3:0] op,
    input  logic       zero,
    input  logic       neg,
    input  logic       rs_zero,
    output logic       taken
);
    always_comb begin
        taken = op == BEQ  ? zero :
                op == BNE  ? !zero :
                op == BGEZ ? !neg :
                op == BGTZ ? !neg && !rs_zero :
                op == BLEZ ? neg || rs_zero :
                op == BLTZ ? neg : 1'b0;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register and next-PC selection with fetch handshake and squash control.
module pc_sequencer
    import npc_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [3:0]       id_op,
    input  logic [31:0]      id_pc_plus_4,
    input  logic [25:0]      id_target,
    input  logic [31:0]      id_rs,
    input  logic [3:0]       ex_op,
    input  logic [31:0]      ex_pc_plus_4,
    input  logic [31:0]      ex_offset,
    input  logic             ex_zero,
    input  logic             ex_neg,
    input  logic             ex_rs_zero,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus_4,
    output logic             if_valid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [CNT_W-1:0] taken_cnt
);
    state_t      state;
    logic [31:0] pend_pc;
    logic        ex_taken;
    logic        id_jump;
    logic        redirect;
    logic [31:0] ex_tgt;
    logic [31:0] id_tgt;
    logic [31:0] target;

    branch_cond u_cond (
        .op      (ex_op),
        .zero    (ex_zero),
        .neg     (ex_neg),
        .rs_zero (ex_rs_zero),
        .taken   (ex_taken)
    );

    // An EX redirect always wins and drops any younger ID jump.
    always_comb begin
        id_jump  = !stall && !ex_taken && (id_op == JUMP || id_op == JAL || id_op == JR);
        redirect = ex_taken || id_jump;
        ex_tgt   = ex_pc_plus_4 + ex_offset;
        id_tgt   = id_op == JR ? id_rs : (id_pc_plus_4 & 32'hF000_0000) | {4'h0, id_target, 2'b00};
        target   = ex_taken ? ex_tgt : id_tgt;
        imem_req   = !rst;
        pc_plus_4  = pc + 32'd4;
        if_valid   = !rst && state != WAIT_KILL && imem_ready && !stall;
        flush_ifid = !rst && redirect;
        flush_idex = !rst && ex_taken;
    end

    // WAIT_KILL parks the redirect in pend_pc until the in-flight stale fetch returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            state     <= RUN;
            pend_pc   <= '0;
            taken_cnt <= '0;
        end else begin
            if (redirect)
                taken_cnt <= taken_cnt + CNT_W'(1);
            if (state == WAIT_KILL) begin
                if (redirect)
                    pend_pc <= target;
                if (imem_ready) begin
                    pc    <= redirect ? target : pend_pc;
                    state <= RUN;
                end
            end else if (imem_ready) begin
                pc    <= redirect ? target : stall ? pc : pc_plus_4;
                state <= RUN;
            end else if (redirect) begin
                pend_pc <= target;
                state   <= WAIT_KILL;
            end else begin
                state <= WAIT;
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table plus reset-in-WAIT_KILL sequence for pc_sequencer.
module tb_pc_sequencer;
    import npc_defs::*;

    logic        clk = 0;
    logic        rst, stall, imem_ready, ex_zero, ex_neg, ex_rs_zero;
    logic [3:0]  id_op, ex_op;
    logic [31:0] id_pc_plus_4, id_rs, ex_pc_plus_4, ex_offset;
    logic [25:0] id_target;
    logic        imem_req, if_valid, flush_ifid, flush_idex;
    logic [31:0] pc, pc_plus_4;
    logic [15:0] taken_cnt;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .stall(stall), .id_op(id_op), .id_pc_plus_4(id_pc_plus_4),
        .id_target(id_target), .id_rs(id_rs), .ex_op(ex_op), .ex_pc_plus_4(ex_pc_plus_4),
        .ex_offset(ex_offset), .ex_zero(ex_zero), .ex_neg(ex_neg), .ex_rs_zero(ex_rs_zero),
        .imem_req(imem_req), .imem_ready(imem_ready), .pc(pc), .pc_plus_4(pc_plus_4),
        .if_valid(if_valid), .flush_ifid(flush_ifid), .flush_idex(flush_idex), .taken_cnt(taken_cnt)
    );

    typedef struct {
        logic        st, rd;
        logic [3:0]  io;
        logic [31:0] ipc;
        logic [25:0] it;
        logic [31:0] irs;
        logic [3:0]  eo;
        logic [31:0] epc, eoff;
        logic        z, n, rz;
        logic        v, fi, fx;
        logic [31:0] npc;
        logic [15:0] cnt;
    } vec_t;

    function automatic vec_t mk(input int st, rd, io, ipc, it, irs, eo, epc, eoff, z, n, rz,
                                 v, fi, fx, npc, cnt);
        vec_t r;
        r.st = st[0]; r.rd = rd[0]; r.io = io[3:0]; r.ipc = ipc; r.it = it[25:0]; r.irs = irs;
        r.eo = eo[3:0]; r.epc = epc; r.eoff = eoff; r.z = z[0]; r.n = n[0]; r.rz = rz[0];
        r.v = v[0]; r.fi = fi[0]; r.fx = fx[0]; r.npc = npc; r.cnt = cnt[15:0];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        stall = t.st; imem_ready = t.rd; id_op = t.io; id_pc_plus_4 = t.ipc; id_target = t.it;
        id_rs = t.irs; ex_op = t.eo; ex_pc_plus_4 = t.epc; ex_offset = t.eoff;
        ex_zero = t.z; ex_neg = t.n; ex_rs_zero = t.rz;
    endtask

    vec_t vecs[28];

    initial begin
        int a = int'(ADD4);
        vec_t t;
        //            st rd io    ipc          it         irs          eo          epc     eoff         z n rz  v fi fx npc          cnt
        vecs[0]  = mk(0, 1, a,    0,           0,         0,           a,          0,      0,           0,0,0, 1,0,0, 32'h3004,    0);
        vecs[1]  = mk(0, 1, a,    0,           0,         0,           a,          0,      0,           0,0,0, 1,0,0, 32'h3008,    0);
        vecs[2]  = mk(0, 1, a,    0,           0,         0,           a,          0,      0,           0,0,0, 1,0,0, 32'h300C,    0);
        vecs[3]  = mk(0, 1, a,    0,           0,         0,           int'(BEQ),  'h3010, 'h20,        1,0,0, 1,1,1, 32'h3030,    1);
        vecs[4]  = mk(0, 1, int'(JUMP), 'h3034, 'h100,    0,           int'(BNE),  'h3038, 'h40,        1,0,0, 1,1,0, 32'h400,     2);
        vecs[5]  = mk(1, 1, int'(JR), 0,       0,         'h4000,      a,          0,      0,           0,0,0, 0,0,0, 32'h400,     2);
        vecs[6]  = mk(1, 1, a,    0,           0,         0,           int'(BLTZ), 'h3040, 32'hFFFFFFF0,0,1,0, 0,1,1, 32'h3030,    3);
        vecs[7]  = mk(0, 1, int'(JAL), 32'hA0000010, 'h3FFFFFF, 0,     int'(BGEZ), 'h50,   'h8,         0,1,0, 1,1,0, 32'hAFFFFFFC,4);
        vecs[8]  = mk(0, 1, int'(JALR), 0,     0,         32'hFFFFFFFC,a,          0,      0,           0,0,0, 1,1,0, 32'hFFFFFFFC,5);
        vecs[9]  = mk(0, 1, a,    0,           0,         0,           a,          0,      0,           0,0,0, 1,0,0, 32'h0,       5);
        vecs[10] = mk(0, 1, int'(JALR), 0,     0,         'h999,       int'(BLEZ), 'h104,  'h100,       0,0,1, 1,1,1, 32'h204,     6);
        vecs[11] = mk(0, 1, a,    0,           0,         0,           int'(BGTZ), 'h60,   'h8,         0,0,1, 1,0,0, 32'h208,     6);
        vecs[12] = mk(0, 1, a,    0,           0,         0,           int'(BEQ),  'h60,   'h8,         0,0,0, 1,0,0, 32'h20C,     6);
        vecs[13] = mk(0, 1, a,    0,           0,         0,           int'(BNE),  'h10,   'h8,         0,0,0, 1,1,1, 32'h18,      7);
        vecs[14] = mk(0, 1, a,    0,           0,         0,           int'(BGEZ), 'h20,   0,           0,0,0, 1,1,1, 32'h20,      8);
        vecs[15] = mk(0, 1, a,    0,           0,         0,           int'(BLTZ), 'h30,   'h8,         0,0,0, 1,0,0, 32'h24,      8);
        vecs[16] = mk(0, 0, a,    0,           0,         0,           a,          0,      0,           0,0,0, 0,0,0, 32'h24,      8);
        vecs[17] = mk(0, 0, a,    0,           0,         0,           int'(BGTZ), 'h3000, 'h100,       0,0,0, 0,1,1, 32'h24,      9);
        vecs[18] = mk(0, 0, a,    0,           0,         0,           a,          0,      0,           0,0,0, 0,0,0, 32'h24,      9);
        vecs[19] = mk(0, 1, a,    0,           0,         0,           a,          0,      0,           0,0,0, 0,0,0, 32'h3100,    9);
        vecs[20] = mk(0, 1, a,    0,           0,         0,           a,          0,      0,           0,0,0, 1,0,0, 32'h3104,    9);
        vecs[21] = mk(0, 0, int'(JUMP), 'h3108, 'h10,     0,           a,          0,      0,           0,0,0, 0,1,0, 32'h3104,    10);
        vecs[22] = mk(0, 1, a,    0,           0,         0,           int'(BEQ),  'h500,  'h4,         1,0,0, 0,1,1, 32'h504,     11);
        vecs[23] = mk(0, 0, a,    0,           0,         0,           a,          0,      0,           0,0,0, 0,0,0, 32'h504,     11);
        vecs[24] = mk(0, 1, a,    0,           0,         0,           a,          0,      0,           0,0,0, 1,0,0, 32'h508,     11);
        vecs[25] = mk(0, 0, a,    0,           0,         0,           int'(BNE),  'h600,  'h10,        0,0,0, 0,1,1, 32'h508,     12);
        vecs[26] = mk(1, 1, int'(JR), 0,       0,         'h777,       a,          0,      0,           0,0,0, 0,0,0, 32'h610,     12);
        vecs[27] = mk(0, 1, a,    0,           0,         0,           a,          0,      0,           0,0,0, 1,0,0, 32'h614,     12);

        // Reset with a taken branch and ready present: reset must dominate.
        rst = 1;
        drive(mk(0, 1, a, 0, 0, 0, int'(BEQ), 'h10, 'h10, 1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 0);
        chk("rst_valid", {31'd0, if_valid}, 0);
        chk("rst_flush", {30'd0, flush_ifid, flush_idex}, 0);
        chk("rst_pc", pc, 32'h3000);
        chk("rst_cnt", {16'd0, taken_cnt}, 0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 28; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_req", i), {31'd0, imem_req}, 1);
            chk($sformatf("v%0d_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].v});
            chk($sformatf("v%0d_fifid", i), {31'd0, flush_ifid}, {31'd0, vecs[i].fi});
            chk($sformatf("v%0d_fidex", i), {31'd0, flush_idex}, {31'd0, vecs[i].fx});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", i), pc, vecs[i].npc);
            chk($sformatf("v%0d_pc4", i), pc_plus_4, vecs[i].npc + 32'd4);
            chk($sformatf("v%0d_cnt", i), {16'd0, taken_cnt}, {16'd0, vecs[i].cnt});
            @(negedge clk);
        end

        // Enter WAIT_KILL, then reset while the pending target is parked.
        drive(mk(0, 0, a, 0, 0, 0, int'(BEQ), 'h900, 'h0, 1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("wk_pc_hold", pc, 32'h614);
        chk("wk_cnt", {16'd0, taken_cnt}, 13);
        @(negedge clk);
        t = mk(0, 1, a, 0, 0, 0, int'(BNE), 'hA00, 'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(t);
        rst = 1;
        #1;
        chk("wkrst_req", {31'd0, imem_req}, 0);
        chk("wkrst_flush", {30'd0, flush_ifid, flush_idex}, 0);
        chk("wkrst_valid", {31'd0, if_valid}, 0);
        @(posedge clk);
        #1;
        chk("wkrst_pc", pc, 32'h3000);
        chk("wkrst_cnt", {16'd0, taken_cnt}, 0);
        @(negedge clk);
        rst = 0;
        drive(mk(0, 1, a, 0, 0, 0, a, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("post_valid", {31'd0, if_valid}, 1);
        @(posedge clk);
        #1;
        chk("post_pc", pc, 32'h3004);
        chk("post_cnt", {16'd0, taken_cnt}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the fetch PC register of the pipelined MIPS core and decides the next PC each cycle.
- Inputs:
  - ID-stage jumps: J/JAL/JR/JALR.
  - EX-stage conditional branches: BEQ/BNE/BGEZ/BGTZ/BLEZ/BLTZ.
  - Load-use stall from the hazard unit.
  - Ready handshake from instruction memory.
- Outputs: the fetch address, the IF/ID valid qualifier, and flush signals for the pipeline registers. There are no delay slots; taken control transfers squash younger instructions.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
CNT_W, 16, width of taken-redirect statistics counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hazard stall: hold PC and IF/ID
id_op  in  4  NPCop of ID instruction (shared codes; ADD4 = none)
id_pc_plus_4  in  32  PC+4 of ID instruction
id_target  in  26  J-format target field
id_rs  in  32  forwarded rs value (JR/JALR target)
ex_op  in  4  NPCop of EX instruction
ex_pc_plus_4  in  32  PC+4 of EX instruction
ex_offset  in  32  sign-extended offset, already shifted left 2
ex_zero  in  1  ALU rs==rt
ex_neg  in  1  rs[31]
ex_rs_zero  in  1  rs==0
imem_req  out  1  fetch request
imem_ready  in  1  instruction returned for current pc
pc  out  32  fetch address; stable while imem_req && !imem_ready
pc_plus_4  out  32  pc + 4
if_valid  out  1  returned instruction may enter IF/ID
flush_ifid  out  1  squash IF/ID this edge
flush_idex  out  1  squash ID/EX this edge
taken_cnt  out  CNT_W  count of taken redirects, wraps

Behaviour:
- Reset, synchronous and dominating all other inputs:
  - pc=RESET_PC, state=RUN, pend_pc=0, taken_cnt=0.
  - imem_req=0 during reset, then 1 from the first cycle after reset.
  - if_valid, flush_ifid and flush_idex are 0 while rst is high.
- EX branch taken conditions:
  - BEQ: ex_zero=1.
  - BNE: ex_zero=0.
  - BGEZ: ex_neg=0.
  - BGTZ: ex_neg=0 and ex_rs_zero=0.
  - BLEZ: ex_neg=1 or ex_rs_zero=1.
  - BLTZ: ex_neg=1.
  - EX target = ex_pc_plus_4 + ex_offset, using 32-bit modulo arithmetic.
- ID redirect:
  - JUMP or JAL: target = {id_pc_plus_4[31:28], id_target, 2'b00}.
  - JR or JALR (shared code 4'b1000): target = id_rs.
  - The ID redirect is ignored while stall=1.
- Priority: EX taken > ID jump > sequential. An EX redirect takes effect even when stall=1.
- Flushes are combinational in the same cycle as the redirect:
  - EX taken: flush_ifid=1 and flush_idex=1; any ID jump is dropped.
  - ID jump: flush_ifid=1 only.
- FSM states: RUN, WAIT, WAIT_KILL.
- RUN or WAIT, imem_ready=1:
  - if_valid = !stall.
  - redirect: pc<=target, taken_cnt+1.
  - else if !stall: pc<=pc+4.
  - else: hold pc.
  - next state = RUN.
- RUN or WAIT, imem_ready=0:
  - pc held, if_valid=0.
  - redirect: pend_pc<=target, taken_cnt+1, next state = WAIT_KILL.
  - else: next state = WAIT.
- WAIT_KILL:
  - pc held, if_valid=0 even when imem_ready=1, because the returned word is stale.
  - A new redirect overwrites pend_pc, with EX priority; taken_cnt+1.
  - On imem_ready=1: pc<=pend_pc (or the new redirect target in that cycle), next state = RUN.
- pc wraps at 32'hFFFF_FFFC + 4 = 0. Bits [1:0] are not checked.
- Reset asserted mid-WAIT_KILL discards pend_pc.

Decomposition:
- Shared package `npc_defs`:
  - NPCop codes JUMP..ADD4 (4'b0000..4'b1111, JR=JALR=4'b1000).
  - FSM state encoding.
  - RESET_PC default.
- One natural sub-module, `branch_cond`: combinational evaluation of ex_op plus flags into a taken bit.

Test Plan:
- Reset then imem_ready=1 for 3 cycles -> pc 3000, 3004, 3008, 300C; if_valid=1; no flushes.
- EX BEQ at ex_pc_plus_4=3010, ex_offset=0x20, ex_zero=1 -> next pc=3030; flush_ifid=flush_idex=1 for one cycle; taken_cnt=1.
- Same cycle: ID JUMP with id_target=0x100 and EX BNE not taken -> pc=00000400 (pc[31:28]=0); only flush_ifid.
- stall=1 with ID JR id_rs=4000 -> pc held, no flush. stall=1 with EX BLTZ taken (ex_neg=1) -> redirect still occurs.
- imem_ready=0 for 2 cycles while EX BGTZ is taken (target 3100) -> pc stays, state WAIT_KILL; when ready rises, if_valid=0 and pc becomes 3100 on that edge.
- rst=1 asserted during WAIT_KILL -> pc=RESET_PC and taken_cnt=0 on that edge; the pending target is never used.
